// File: rtl/bcd_seq_converter.sv
// Serial binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// START/BUSY/VALID handshake, optional two's-complement input, overflow flag.
module bcd_seq_converter #(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned DIGITS    = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_signed_mode,
    input  logic [BIN_WIDTH-1:0]   i_bin,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [4*DIGITS-1:0]    o_bcd,
    output logic                   o_neg,
    output logic                   o_ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [BIN_WIDTH-1:0] r_mag;
    logic [BCD_W-1:0]     r_digits;
    logic                 r_ovf_acc;
    logic                 r_neg_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_valid;
    logic [BCD_W-1:0]     r_bcd;
    logic                 r_neg;
    logic                 r_ovf;

    logic [BIN_WIDTH-1:0] w_mag;
    logic [BCD_W-1:0]     w_digits;
    logic                 w_ovf_acc;
    logic                 w_neg_nxt;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_busy;
    logic                 w_valid;
    logic [BCD_W-1:0]     w_bcd;
    logic                 w_neg;
    logic                 w_ovf;
    logic [BCD_W-1:0]     w_adj;
    logic                 w_is_neg;

    // Add-3 correction: each digit independently, 4-bit add, no inter-digit carry
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_digits[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_digits[4*k +: 4] + 4'd3;
            end else begin
                w_adj[4*k +: 4] = r_digits[4*k +: 4];
            end
        end
    end

    assign w_is_neg = i_signed_mode & i_bin[BIN_WIDTH-1];

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt = r_state;
        w_mag       = r_mag;
        w_digits    = r_digits;
        w_ovf_acc   = r_ovf_acc;
        w_neg_nxt   = r_neg_nxt;
        w_cnt       = r_cnt;
        w_valid     = 1'b0;
        w_bcd       = r_bcd;
        w_neg       = r_neg;
        w_ovf       = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_mag       = w_is_neg ? BIN_WIDTH'(~i_bin + BIN_WIDTH'(1)) : i_bin;
                    w_neg_nxt   = w_is_neg;
                    w_digits    = '0;
                    w_ovf_acc   = 1'b0;
                    w_cnt       = CNT_W'(BIN_WIDTH);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_digits  = {w_adj[BCD_W-2:0], r_mag[BIN_WIDTH-1]};
                w_mag     = {r_mag[BIN_WIDTH-2:0], 1'b0};
                w_ovf_acc = r_ovf_acc | w_adj[BCD_W-1];
                w_cnt     = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_bcd       = r_digits;
                w_neg       = r_neg_nxt;
                w_ovf       = r_ovf_acc;
                w_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy = (w_state_nxt != S_IDLE);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mag     <= '0;
            r_digits  <= '0;
            r_ovf_acc <= 1'b0;
            r_neg_nxt <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bcd     <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_mag     <= w_mag;
            r_digits  <= w_digits;
            r_ovf_acc <= w_ovf_acc;
            r_neg_nxt <= w_neg_nxt;
            r_cnt     <= w_cnt;
            r_busy    <= w_busy;
            r_valid   <= w_valid;
            r_bcd     <= w_bcd;
            r_neg     <= w_neg;
            r_ovf     <= w_ovf;
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_bcd   = r_bcd;
    assign o_neg   = r_neg;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench: a 5-digit and a 4-digit converter share one stimulus stream,
// expected results come from a decimal-arithmetic reference model.
module tb_bcd_seq_converter;

    localparam int unsigned W   = 16;
    localparam int unsigned LAT = W + 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sm;
    logic [15:0] bin;

    logic        busy5, valid5, neg5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, valid4, neg4, ovf4;
    logic [15:0] bcd4;

    bcd_seq_converter #(.BIN_WIDTH(16), .DIGITS(5)) u_dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed_mode(sm), .i_bin(bin),
        .o_busy(busy5), .o_valid(valid5), .o_bcd(bcd5), .o_neg(neg5), .o_ovf(ovf5)
    );

    bcd_seq_converter #(.BIN_WIDTH(16), .DIGITS(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed_mode(sm), .i_bin(bin),
        .o_busy(busy4), .o_valid(valid4), .o_bcd(bcd4), .o_neg(neg4), .o_ovf(ovf4)
    );

    typedef struct {
        logic [19:0] bcd5;
        logic [15:0] bcd4;
        logic        ovf5;
        logic        ovf4;
        logic        neg;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    exp_t        last;
    int unsigned cyc;
    int unsigned cnt;
    int          errors;
    int          checks;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] to_bcd(input longint unsigned v, input int nd);
        logic [39:0]      r;
        longint unsigned  m;
        r = '0;
        m = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [15:0] b, input logic s, input int unsigned due);
        exp_t            e;
        longint unsigned mag;
        mag   = longint'(b);
        e.neg = s && b[15];
        if (e.neg) mag = 65536 - mag;
        e.ovf5 = (mag > 99999);
        e.ovf4 = (mag > 9999);
        e.bcd5 = 20'(to_bcd(mag % 100000, 5));
        e.bcd4 = 16'(to_bcd(mag % 10000, 4));
        e.due  = due;
        return e;
    endfunction

    // Reference acceptance model: a START is taken only when no conversion is outstanding
    initial begin
        cyc = 0;
        cnt = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cnt = 0;
            end else begin
                cyc++;
                if (cnt != 0) begin
                    cnt--;
                end else if (start) begin
                    q.push_back(model(bin, sm, cyc + LAT));
                    cnt = LAT;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard away from the active edge
    initial begin
        exp_t e;
        logic exp_v;
        last = '{default: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                last = '{default: 0};
            end
            exp_v = (q.size() != 0) && (q[0].due == cyc);
            chk("valid5", 64'(valid5), 64'(exp_v));
            chk("valid4", 64'(valid4), 64'(exp_v));
            if ((valid5 || exp_v) && q.size() != 0) begin
                e = q.pop_front();
                chk("latency", 64'(cyc), 64'(e.due));
                last = e;
            end
            chk("busy5", 64'(busy5), 64'(cnt != 0));
            chk("busy4", 64'(busy4), 64'(cnt != 0));
            chk("bcd5", 64'(bcd5), 64'(last.bcd5));
            chk("bcd4", 64'(bcd4), 64'(last.bcd4));
            chk("neg5", 64'(neg5), 64'(last.neg));
            chk("neg4", 64'(neg4), 64'(last.neg));
            chk("ovf5", 64'(ovf5), 64'(last.ovf5));
            chk("ovf4", 64'(ovf4), 64'(last.ovf4));
        end
    end

    task automatic issue(input logic [15:0] b, input logic s);
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        sm    = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] picks [8];
        int          guard;
        picks = '{16'd0, 16'd9999, 16'd10000, 16'd65535, 16'h8000, 16'h7FFF, 16'hFFFF, 16'd1};
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sm     = 1'b0;
        bin    = '0;
        idle(3);
        chk("rst_busy", 64'(busy5), 64'(0));
        chk("rst_valid", 64'(valid5), 64'(0));
        chk("rst_bcd5", 64'(bcd5), 64'(0));
        chk("rst_bcd4", 64'(bcd4), 64'(0));
        rst_n = 1'b1;
        idle(2);

        issue(16'd65535, 1'b0); idle(LAT + 1);
        issue(16'd12345, 1'b0); idle(LAT + 1);
        issue(16'd9999,  1'b0); idle(LAT + 1);
        issue(16'hFFFF,  1'b1); idle(LAT + 1);
        issue(16'h8000,  1'b1); idle(LAT + 1);
        issue(16'd0,     1'b1); idle(LAT + 1);

        // Extra STARTs at edges 3 and 17, BIN changed before edge 5: all ignored
        issue(16'd1234, 1'b0);
        idle(2);
        start = 1'b1; bin = 16'd777;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bin = 16'd4321; sm = 1'b1;
        idle(12);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(4);

        // START held high: back-to-back conversions
        @(negedge clk);
        start = 1'b1; bin = 16'd10; sm = 1'b0;
        @(negedge clk);
        bin = 16'd9;
        idle(LAT + 1);
        start = 1'b0;
        idle(LAT + 2);

        // Reset mid-conversion at edge 6
        issue(16'd54321, 1'b0);
        idle(5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy5", 64'(busy5), 64'(0));
        chk("midrst_busy4", 64'(busy4), 64'(0));
        chk("midrst_valid", 64'(valid5), 64'(0));
        chk("midrst_bcd5", 64'(bcd5), 64'(0));
        idle(2);
        rst_n = 1'b1;
        issue(16'd0, 1'b0); idle(LAT + 2);

        // Random traffic, random START pulses during and between conversions
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            sm    = 1'(($urandom));
            if ($urandom_range(3) == 0) bin = picks[$urandom_range(7)];
            else                        bin = 16'($urandom);
        end
        @(negedge clk);
        start = 1'b0;

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 64'(q.size()), 64'(0));
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
